// File: rtl/pinwheel_console_hub.sv
// pinwheel_console_hub: byte-stream console hub on the pinwheel data bus.
// Each channel owns a FIFO that the core fills through a DATA register and
// the host empties through a valid/ready drain port. A STATUS register
// exposes the count and flags and clears the sticky overflow bit.
module pinwheel_console_hub #(
  parameter int         NUM_CHAN = 4,
  parameter int         DEPTH    = 16,
  parameter logic [3:0] TAG_BASE = 4'h4
) (
  input  logic                  clock,
  input  logic                  reset_in,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  input  logic [3:0]            bus_wmask,
  input  logic                  bus_wren,
  output logic [31:0]           bus_rdata,
  output logic                  bus_hit,
  output logic [NUM_CHAN-1:0]   drain_valid,
  output logic [8*NUM_CHAN-1:0] drain_data,
  input  logic [NUM_CHAN-1:0]   drain_ready,
  output logic [NUM_CHAN-1:0]   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Address decode results
  logic [3:0]          tag;
  logic [3:0]          rel;
  logic                hit;
  logic [1:0]          off;
  logic [NUM_CHAN-1:0] sel;

  // Per-channel handshake terms
  logic [NUM_CHAN-1:0] push;
  logic [NUM_CHAN-1:0] pop;
  logic [NUM_CHAN-1:0] full;
  logic [NUM_CHAN-1:0] wr_en;
  logic [NUM_CHAN-1:0] drop;
  logic [NUM_CHAN-1:0] clr;

  // Per-channel FIFO state
  logic [PW-1:0] wr_ptr_q [NUM_CHAN];
  logic [PW-1:0] wr_ptr_d [NUM_CHAN];
  logic [PW-1:0] rd_ptr_q [NUM_CHAN];
  logic [PW-1:0] rd_ptr_d [NUM_CHAN];
  logic [CW-1:0] count_q  [NUM_CHAN];
  logic [CW-1:0] count_d  [NUM_CHAN];
  logic [NUM_CHAN-1:0] overflow_q;
  logic [NUM_CHAN-1:0] overflow_d;

  // FIFO storage, deliberately left out of reset
  logic [7:0] fifo_mem [NUM_CHAN][DEPTH];

  // Registered read port
  logic        bus_hit_q;
  logic        bus_hit_d;
  logic [31:0] bus_rdata_q;
  logic [31:0] bus_rdata_d;
  logic [7:0]  cnt8;

  // Bus bits the hub never looks at
  logic unused_bits;
  assign unused_bits = ^{bus_addr[27:4], bus_addr[1:0], bus_wdata[31:8], bus_wmask[3:1]};

  // Decode the tag nibble into a hit flag and a one-hot channel select
  always_comb begin
    tag = bus_addr[31:28];
    rel = tag - TAG_BASE;
    off = bus_addr[3:2];
    hit = ({28'b0, rel} < 32'(NUM_CHAN));
    sel = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      sel[i] = hit && ({28'b0, rel} == 32'(i));
    end
  end

  // Drain port: head byte and non-empty flag straight from the FIFO state
  always_comb begin
    drain_valid = '0;
    drain_data  = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      drain_valid[i]      = (count_q[i] != '0);
      drain_data[8*i +: 8] = fifo_mem[i][rd_ptr_q[i]];
    end
  end

  // Push/pop arbitration and next pointer, count and overflow per channel
  always_comb begin
    push       = '0;
    pop        = '0;
    full       = '0;
    wr_en      = '0;
    drop       = '0;
    clr        = '0;
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CHAN; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];

      push[i]  = sel[i] && bus_wren && bus_wmask[0] && (off == 2'd0);
      clr[i]   = sel[i] && bus_wren && bus_wmask[0] && (off == 2'd1) && bus_wdata[0];
      pop[i]   = drain_valid[i] && drain_ready[i];
      full[i]  = (count_q[i] == CW'(DEPTH));
      // A simultaneous pop frees the slot, so a push into a full FIFO survives
      wr_en[i] = push[i] && (!full[i] || pop[i]);
      drop[i]  = push[i] && full[i] && !pop[i];

      if (wr_en[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      if (wr_en[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CW'(1);
      end else if (!wr_en[i] && pop[i]) begin
        count_d[i] = count_q[i] - CW'(1);
      end

      // A drop in the same cycle as a clear leaves the flag set
      if (drop[i]) begin
        overflow_d[i] = 1'b1;
      end else if (clr[i]) begin
        overflow_d[i] = 1'b0;
      end
    end
  end

  // Status word for the addressed channel, sampled from pre-edge state
  always_comb begin
    bus_hit_d   = hit;
    bus_rdata_d = '0;
    cnt8        = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (sel[i] && (off == 2'd1)) begin
        cnt8         = '0;
        cnt8[CW-1:0] = count_q[i];
        bus_rdata_d  = {16'b0, cnt8, 5'b0, overflow_q[i], full[i], (count_q[i] == '0)};
      end
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      overflow_q  <= '0;
      bus_hit_q   <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      overflow_q  <= overflow_d;
      bus_hit_q   <= bus_hit_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  // FIFO storage write; stale contents are hidden by drain_valid after reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (wr_en[i]) begin
        fifo_mem[i][wr_ptr_q[i]] <= bus_wdata[7:0];
      end
    end
  end

  assign bus_hit   = bus_hit_q;
  assign bus_rdata = bus_rdata_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pinwheel_console_hub.sv
// tb_pinwheel_console_hub: directed bench for the console hub.
module tb_pinwheel_console_hub;

  logic        clock;
  logic        reset_in;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_wren;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic [3:0]  drain_valid;
  logic [31:0] drain_data;
  logic [3:0]  drain_ready;
  logic [3:0]  overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wren;
    logic        exp_hit;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] model [$];
  int         pushed;
  int         popped;
  int         cycles;
  logic       do_push;
  logic       rdy;

  pinwheel_console_hub #(
    .NUM_CHAN (4),
    .DEPTH    (16),
    .TAG_BASE (4'h4)
  ) dut (
    .clock       (clock),
    .reset_in    (reset_in),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wmask   (bus_wmask),
    .bus_wren    (bus_wren),
    .bus_rdata   (bus_rdata),
    .bus_hit     (bus_hit),
    .drain_valid (drain_valid),
    .drain_data  (drain_data),
    .drain_ready (drain_ready),
    .overflow    (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one bus cycle and return 1 time unit after the clock edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input logic wren,
                               input logic [3:0] ready);
    bus_addr    = addr;
    bus_wdata   = wdata;
    bus_wmask   = wmask;
    bus_wren    = wren;
    drain_ready = ready;
    @(posedge clock);
    #1;
  endtask

  // Compare one value against its expectation
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h55, 4'b0001, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[1] = '{32'h4000_0008, 32'h55, 4'b0001, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{32'h4000_0000, 32'h55, 4'b1110, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h4000_0000, 32'h55, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{32'h4000_0004, 32'h0,  4'b0000, 1'b0, 1'b1, 1'b1, 32'h0000_0001};
    vecs[5] = '{32'h5000_000C, 32'h1,  4'b0001, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[6] = '{32'h3000_0004, 32'h0,  4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{32'hC000_0004, 32'h0,  4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{32'h7000_0004, 32'h0,  4'b0000, 1'b0, 1'b1, 1'b1, 32'h0000_0001};
    vecs[9] = '{32'h6000_0004, 32'h0,  4'b0000, 1'b0, 1'b1, 1'b1, 32'h0000_0001};

    reset_in    = 1'b1;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_wmask   = '0;
    bus_wren    = 1'b0;
    drain_ready = '0;
    repeat (2) @(posedge clock);
    #3 reset_in = 1'b0;

    // Test 1: reset state, single push and pop
    $display("[TB] test 1: reset and single byte");
    checkOutput("rst_valid", {28'b0, drain_valid}, 32'h0);
    checkOutput("rst_ovf", {28'b0, overflow}, 32'h0);
    checkOutput("rst_hit", {31'b0, bus_hit}, 32'h0);
    checkOutput("rst_rdata", bus_rdata, 32'h0);
    applyStimulus(32'h4000_0000, 32'h0000_0041, 4'b0001, 1'b1, 4'b0000);
    checkOutput("t1_valid", {28'b0, drain_valid}, 32'h1);
    checkOutput("t1_data", {24'b0, drain_data[7:0]}, 32'h41);
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 4'b0001);
    checkOutput("t1_pop", {28'b0, drain_valid}, 32'h0);

    // Test 2: overflow on channel 1, status read and clear
    $display("[TB] test 2: overflow and status");
    for (int k = 0; k < 17; k++) begin
      applyStimulus(32'h5000_0000, 32'(k), 4'b0001, 1'b1, 4'b0000);
      if (k == 15) checkOutput("t2_ovf_at_full", {31'b0, overflow[1]}, 32'h0);
    end
    checkOutput("t2_ovf_set", {31'b0, overflow[1]}, 32'h1);
    applyStimulus(32'h5000_0004, 32'h0, 4'b0000, 1'b0, 4'b0000);
    checkOutput("t2_hit", {31'b0, bus_hit}, 32'h1);
    checkOutput("t2_status", bus_rdata, 32'h0000_1006);
    applyStimulus(32'h5000_0004, 32'h1, 4'b0001, 1'b1, 4'b0000);
    checkOutput("t2_ovf_clr", {31'b0, overflow[1]}, 32'h0);
    applyStimulus(32'h5000_0004, 32'h0, 4'b0000, 1'b0, 4'b0000);
    checkOutput("t2_status_clr", bus_rdata, 32'h0000_1002);
    for (int k = 0; k < 16; k++) begin
      checkOutput("t2_drain_valid", {31'b0, drain_valid[1]}, 32'h1);
      checkOutput("t2_drain_data", {24'b0, drain_data[15:8]}, 32'(k));
      applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 4'b0010);
    end
    checkOutput("t2_empty", {31'b0, drain_valid[1]}, 32'h0);

    // Test 3: push and pop on a full channel in the same cycle
    $display("[TB] test 3: full with simultaneous push and pop");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(32'h6000_0000, 32'(8'hB0 + k), 4'b0001, 1'b1, 4'b0000);
    end
    applyStimulus(32'h6000_0004, 32'h0, 4'b0000, 1'b0, 4'b0000);
    checkOutput("t3_status_full", bus_rdata, 32'h0000_1002);
    checkOutput("t3_head", {24'b0, drain_data[23:16]}, 32'hB0);
    applyStimulus(32'h6000_0000, 32'h0000_00AA, 4'b0001, 1'b1, 4'b0100);
    checkOutput("t3_ovf", {31'b0, overflow[2]}, 32'h0);
    applyStimulus(32'h6000_0004, 32'h0, 4'b0000, 1'b0, 4'b0000);
    checkOutput("t3_status_after", bus_rdata, 32'h0000_1002);
    for (int k = 0; k < 16; k++) begin
      checkOutput("t3_drain_data", {24'b0, drain_data[23:16]}, (k == 15) ? 32'hAA : 32'(8'hB1 + k));
      applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 4'b0100);
    end
    checkOutput("t3_empty", {31'b0, drain_valid[2]}, 32'h0);

    // Test 4: random push/pop mix on channel 3 against a queue model
    $display("[TB] test 4: random stream on channel 3");
    pushed = 0;
    popped = 0;
    cycles = 0;
    while ((pushed < 40 || popped < 40) && cycles < 1000) begin
      cycles++;
      do_push = (pushed < 40) && (model.size() < 16) && ($urandom_range(0, 2) != 0);
      rdy     = ($urandom_range(0, 1) == 1);
      checkOutput("t4_valid", {31'b0, drain_valid[3]}, {31'b0, (model.size() != 0)});
      if (rdy && model.size() != 0) begin
        checkOutput("t4_order", {24'b0, drain_data[31:24]}, {24'b0, model[0]});
      end
      applyStimulus(do_push ? 32'h7000_0000 : 32'h0, 32'(8'hC0 + pushed), 4'b0001,
                    do_push, {rdy, 3'b000});
      if (rdy && model.size() != 0) begin
        void'(model.pop_front());
        popped++;
      end
      if (do_push) begin
        model.push_back(8'(8'hC0 + pushed));
        pushed++;
      end
    end
    checkOutput("t4_pushed", 32'(pushed), 32'd40);
    checkOutput("t4_popped", 32'(popped), 32'd40);
    checkOutput("t4_ovf", {31'b0, overflow[3]}, 32'h0);

    // Test 5: decode and reserved-register table
    $display("[TB] test 5: decode table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].wren, 4'b0000);
      checkOutput($sformatf("t5_hit_%0d", v), {31'b0, bus_hit}, {31'b0, vecs[v].exp_hit});
      if (vecs[v].chk_rdata) begin
        checkOutput($sformatf("t5_rdata_%0d", v), bus_rdata, vecs[v].exp_rdata);
      end
      checkOutput($sformatf("t5_valid_%0d", v), {28'b0, drain_valid}, 32'h0);
    end

    // Test 6: asynchronous reset between edges
    $display("[TB] test 6: mid-transfer reset");
    for (int k = 0; k < 17; k++) begin
      applyStimulus(32'h5000_0000, 32'(8'h20 + k), 4'b0001, 1'b1, 4'b0000);
    end
    checkOutput("t6_ovf1", {31'b0, overflow[1]}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'h4000_0000, 32'(8'h10 + k), 4'b0001, 1'b1, 4'b0000);
    end
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 4'b0001);
    checkOutput("t6_head", {24'b0, drain_data[7:0]}, 32'h11);
    #2 reset_in = 1'b1;
    #1;
    checkOutput("t6_rst_valid", {28'b0, drain_valid}, 32'h0);
    checkOutput("t6_rst_ovf", {28'b0, overflow}, 32'h0);
    drain_ready = 4'b0000;
    #1 reset_in = 1'b0;
    applyStimulus(32'h4000_0000, 32'h0000_007E, 4'b0001, 1'b1, 4'b0000);
    checkOutput("t6_new_valid", {28'b0, drain_valid}, 32'h1);
    checkOutput("t6_new_head", {24'b0, drain_data[7:0]}, 32'h7E);
    applyStimulus(32'h4000_0000, 32'h0000_007F, 4'b0001, 1'b1, 4'b0000);
    applyStimulus(32'h4000_0004, 32'h0, 4'b0000, 1'b0, 4'b0001);
    checkOutput("t6_status", bus_rdata, 32'h0000_0200);
    checkOutput("t6_second", {24'b0, drain_data[7:0]}, 32'h7F);
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 4'b0001);
    checkOutput("t6_drained", {28'b0, drain_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
